decoder_bank: RTL and testbench

- Bank of three one-hot binary decoders (1-to-2, 2-to-4, 3-to-8) sharing one active-high enable.
- Each decoder drives a combinational output and a registered copy of that output.
- Used wherever a select field is expanded to one-hot strobes, e.g. register-file write enables or mux selects.
- The larger decoders are built hierarchically from the smaller ones.

---
 rtl/decoder_bank.sv | 43 ++++
 tb/tb_decoder_bank.sv | 129 ++++++++++++
 2 files changed

// File: rtl/decoder_bank.sv
// decoder_bank: enabled 1-to-2, 2-to-4 and 3-to-8 one-hot decoders with registered copies
module decoder_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       in_1_to_2,
  input  logic [1:0] in_2_to_4,
  input  logic [2:0] in_3_to_8,
  output logic [1:0] out_1_to_2,
  output logic [3:0] out_2_to_4,
  output logic [7:0] out_3_to_8,
  output logic [1:0] q_1_to_2,
  output logic [3:0] q_2_to_4,
  output logic [7:0] q_3_to_8
);
  function automatic logic [1:0] dec1(input logic en, input logic s);
    return {en & s, en & ~s};
  endfunction
  // Wider decoders: the MSB picks which half's sub-decoder is enabled.
  function automatic logic [3:0] dec2(input logic en, input logic [1:0] s);
    logic [1:0] h;
    h = dec1(en, s[1]);
    return {dec1(h[1], s[0]), dec1(h[0], s[0])};
  endfunction
  function automatic logic [7:0] dec3(input logic en, input logic [2:0] s);
    logic [1:0] h;
    h = dec1(en, s[2]);
    return {dec2(h[1], s[1:0]), dec2(h[0], s[1:0])};
  endfunction
  assign out_1_to_2 = dec1(ena, in_1_to_2);
  assign out_2_to_4 = dec2(ena, in_2_to_4);
  assign out_3_to_8 = dec3(ena, in_3_to_8);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_1_to_2 <= '0;
      q_2_to_4 <= '0;
      q_3_to_8 <= '0;
    end else begin
      q_1_to_2 <= out_1_to_2;
      q_2_to_4 <= out_2_to_4;
      q_3_to_8 <= out_3_to_8;
    end
endmodule

// File: tb/tb_decoder_bank.sv
// tb_decoder_bank: random and directed checks of decoder_bank against a shift-based model
module tb_decoder_bank;
  logic clk = 0, rst = 1, ena = 0, in_1_to_2 = 0;
  logic [1:0] in_2_to_4 = 0;
  logic [2:0] in_3_to_8 = 0;
  logic [1:0] out_1_to_2, q_1_to_2;
  logic [3:0] out_2_to_4, q_2_to_4;
  logic [7:0] out_3_to_8, q_3_to_8;
  logic [7:0] mq1, mq2, mq3;
  logic go = 0;
  int checks = 0, errors = 0;

  decoder_bank dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_1_to_2(in_1_to_2), .in_2_to_4(in_2_to_4), .in_3_to_8(in_3_to_8),
    .out_1_to_2(out_1_to_2), .out_2_to_4(out_2_to_4), .out_3_to_8(out_3_to_8),
    .q_1_to_2(q_1_to_2), .q_2_to_4(q_2_to_4), .q_3_to_8(q_3_to_8)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dec(input logic e, input int s);
    return e ? 8'(1 << s) : 8'h00;
  endfunction

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference copy of the registered outputs, cleared asynchronously like the design.
  always @(posedge clk or posedge rst)
    if (rst) begin
      mq1 <= 0;
      mq2 <= 0;
      mq3 <= 0;
    end else begin
      mq1 <= dec(ena, int'(in_1_to_2));
      mq2 <= dec(ena, int'(in_2_to_4));
      mq3 <= dec(ena, int'(in_3_to_8));
    end

  always @(negedge clk)
    if (go) begin
      chk("out_1_to_2", {6'b0, out_1_to_2}, dec(ena, int'(in_1_to_2)));
      chk("out_2_to_4", {4'b0, out_2_to_4}, dec(ena, int'(in_2_to_4)));
      chk("out_3_to_8", out_3_to_8, dec(ena, int'(in_3_to_8)));
      chk("q_1_to_2", {6'b0, q_1_to_2}, mq1);
      chk("q_2_to_4", {4'b0, q_2_to_4}, mq2);
      chk("q_3_to_8", q_3_to_8, mq3);
    end

  task automatic step(input logic e, input logic a, input logic [1:0] b, input logic [2:0] c);
    @(posedge clk);
    #1;
    ena = e;
    in_1_to_2 = a;
    in_2_to_4 = b;
    in_3_to_8 = c;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q1", {6'b0, q_1_to_2}, 8'h00);
    chk("reset_q2", {4'b0, q_2_to_4}, 8'h00);
    chk("reset_q3", q_3_to_8, 8'h00);
    rst = 0;
    go = 1;
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < 8; i++)
        step(e[0], i[0], i[1:0], i[2:0]);
    step(1, 0, 2, 5);
    #1;
    chk("spot_out3_5", out_3_to_8, 8'h20);
    chk("spot_out2_2", {4'b0, out_2_to_4}, 8'h04);
    chk("spot_out1_0", {6'b0, out_1_to_2}, 8'h01);
    step(1, 1, 3, 7);
    #1;
    chk("max_out3", out_3_to_8, 8'h80);
    chk("max_out2", {4'b0, out_2_to_4}, 8'h08);
    chk("max_out1", {6'b0, out_1_to_2}, 8'h02);
    step(1, 0, 0, 3);
    step(1, 0, 0, 6);
    #1;
    chk("q3_capture_3", q_3_to_8, 8'h08);
    @(posedge clk);
    #1;
    chk("q3_capture_6", q_3_to_8, 8'h40);
    step(1, 0, 1, 0);
    @(posedge clk);
    #2;
    chk("q2_before_rst", {4'b0, q_2_to_4}, 8'h02);
    rst = 1;
    #1;
    chk("q2_async_rst", {4'b0, q_2_to_4}, 8'h00);
    chk("out2_during_rst", {4'b0, out_2_to_4}, 8'h02);
    rst = 0;
    @(posedge clk);
    #1;
    chk("q2_after_rst", {4'b0, q_2_to_4}, 8'h02);
    step(1, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("out1_en", {6'b0, out_1_to_2}, 8'h02);
    chk("q1_en", {6'b0, q_1_to_2}, 8'h02);
    ena = 0;
    #1;
    chk("out1_drop", {6'b0, out_1_to_2}, 8'h00);
    chk("q1_hold", {6'b0, q_1_to_2}, 8'h02);
    @(posedge clk);
    #1;
    chk("q1_drop", {6'b0, q_1_to_2}, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      step(i[0], 1'($urandom), 2'($urandom), 3'($urandom));
      rst = ($urandom_range(0, 39) == 0);
    end
    step(0, 0, 0, 0);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    go = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
